// File: rtl/wfg_dds_if.sv
// wfg_dds control and sample bundle.
// Master drives the controls, slave returns wave/wrap.
interface wfg_dds_if #(
  parameter int W  = 8,
  parameter int PW = 16
);
  logic          en;
  logic [2:0]    func;
  logic [PW-1:0] step;
  logic [W-1:0]  duty;
  logic [2:0]    atten;
  logic [W-1:0]  wave;
  logic          wrap;

  modport master (
    output en, func, step, duty, atten,
    input  wave, wrap
  );

  modport slave (
    input  en, func, step, duty, atten,
    output wave, wrap
  );
endinterface

// File: rtl/wfg_dds.sv
// Phase-accumulator waveform generator, eight modes.
// Registered W-bit sample plus one-cycle wrap pulse per period.
module wfg_dds #(
  parameter int W  = 8,
  parameter int PW = 16,
  parameter logic [W-1:0] TAPS = 8'hB8
) (
  input logic      clk,
  input logic      rst,
  wfg_dds_if.slave dds
);
  localparam logic [W-1:0] MAX   = '1;
  localparam logic [W-1:0] STAIR = MAX << (W / 2);
  localparam int           SH    = W - 2;

  logic [PW-1:0]  acc_q, acc_d;
  logic [W-1:0]   lfsr_q, lfsr_d;
  logic [W-1:0]   wave_q, wave_d;
  logic [2:0]     func_q, func_d;
  logic           wrap_q, wrap_d;

  logic [PW:0]    sum;
  logic [W-1:0]   p, t, tri_v, raw, lfsr_nx;
  logic [2*W-1:0] prod;
  logic           mode_chg;

  assign p        = acc_q[PW-1 -: W];
  assign t        = {p[W-2:0], 1'b0};
  assign tri_v    = p[W-1] ? ~t : t;
  assign prod     = {{W{1'b0}}, tri_v}
                  * {{W{1'b0}}, MAX - tri_v};
  assign sum      = {1'b0, acc_q} + {1'b0, dds.step};
  assign mode_chg = dds.func != func_q;
  assign lfsr_nx  = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS)
                              : (lfsr_q >> 1);

  always_comb begin
    raw = wave_q;
    unique case (dds.func)
      3'd0: raw = p;
      3'd1: raw = MAX - p;
      3'd2: raw = tri_v;
      3'd3: raw = (p < dds.duty) ? MAX : '0;
      3'd4: raw = p & STAIR;
      3'd5: raw = lfsr_q;
      3'd6: raw = W'(prod >> SH);
      3'd7: raw = wave_q;
    endcase
  end

  // A mode change restarts the period; the sample still uses the old phase.
  always_comb begin
    acc_d  = acc_q;
    lfsr_d = lfsr_q;
    wave_d = wave_q;
    func_d = func_q;
    wrap_d = 1'b0;
    if (dds.en) begin
      wave_d = raw >> dds.atten;
      if (mode_chg) begin
        acc_d  = '0;
        func_d = dds.func;
      end else begin
        {wrap_d, acc_d} = sum;
      end
      if (dds.func == 3'd5) lfsr_d = lfsr_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      lfsr_q <= W'(1);
      wave_q <= '0;
      func_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      lfsr_q <= lfsr_d;
      wave_q <= wave_d;
      func_q <= func_d;
      wrap_q <= wrap_d;
    end
  end

  assign dds.wave = wave_q;
  assign dds.wrap = wrap_q;
endmodule

// File: tb/tb_wfg_dds.sv
// Self-checking bench for wfg_dds.
// Directed scenarios plus randomized run against an arithmetic model.
module tb_wfg_dds;
  localparam int W      = 8;
  localparam int PW     = 16;
  localparam int MAX    = (1 << W) - 1;
  localparam int TAPS_I = 'hB8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  int m_acc, m_lfsr, m_func, m_wave, m_wrap;

  wfg_dds_if #(.W(W), .PW(PW)) dif ();

  wfg_dds #(.W(W), .PW(PW), .TAPS(8'hB8)) dut (
    .clk (clk),
    .rst (rst),
    .dds (dif)
  );

  always #5 clk = ~clk;

  function automatic int model_raw(int f, int p, int dty);
    int q;
    q = (p <= MAX / 2) ? 2 * p : 2 * (MAX - p) + 1;
    case (f)
      0: return p;
      1: return MAX - p;
      2: return q;
      3: return (p < dty) ? MAX : 0;
      4: return (p / (1 << (W / 2))) * (1 << (W / 2));
      5: return m_lfsr;
      6: return (q * (MAX - q)) / (1 << (W - 2));
      default: return m_wave;
    endcase
  endfunction

  task automatic model_reset();
    m_acc = 0; m_lfsr = 1; m_func = 0; m_wave = 0; m_wrap = 0;
  endtask

  task automatic cycle();
    int p, s, nw, na, nl, nf, nr;
    nw = m_wave; na = m_acc; nl = m_lfsr; nf = m_func; nr = 0;
    if (dif.en === 1'b1) begin
      p  = m_acc / (1 << (PW - W));
      nw = model_raw(int'(dif.func), p, int'(dif.duty))
           / (1 << dif.atten);
      s  = m_acc + int'(dif.step);
      if (int'(dif.func) != m_func) begin
        na = 0;
        nf = int'(dif.func);
      end else begin
        na = s % (1 << PW);
        nr = (s >= (1 << PW)) ? 1 : 0;
      end
      if (dif.func == 3'd5)
        nl = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ TAPS_I) : m_lfsr / 2;
    end
    @(posedge clk);
    m_wave = nw; m_acc = na; m_lfsr = nl; m_func = nf; m_wrap = nr;
    @(negedge clk);
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    nvec++;
    if (dif.wave !== '0) begin
      nerr++;
      $display("FAIL async_rst_wave got=%0d want=0", dif.wave);
    end
    nvec++;
    if (dif.wrap !== 1'b0) begin
      nerr++;
      $display("FAIL async_rst_wrap got=%0b want=0", dif.wrap);
    end
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int nwrap;
    dif.func = 3'd0; dif.step = 16'h0100; dif.en = 1'b1;
    dif.atten = 3'd0; dif.duty = 8'd0;
    nvec++;
    if (dif.wave !== '0 || dif.wrap !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state wave=%0d wrap=%0b want 0/0",
               dif.wave, dif.wrap);
    end
    repeat (40) cycle();
    async_reset();
    nwrap = 0;
    for (int k = 1; k <= 600; k++) begin
      cycle();
      nvec++;
      if (dif.wave !== W'((k - 1) % 256)) begin
        nerr++;
        $display("FAIL ramp k=%0d got=%0d want=%0d",
                 k, dif.wave, (k - 1) % 256);
      end
      nvec++;
      if (dif.wrap !== ((k % 256) == 0)) begin
        nerr++;
        $display("FAIL ramp_wrap k=%0d got=%0b want=%0b",
                 k, dif.wrap, (k % 256) == 0);
      end
      if (dif.wrap === 1'b1) nwrap++;
    end
    nvec++;
    if (nwrap != 2) begin
      nerr++;
      $display("FAIL ramp_wrap_count got=%0d want=2", nwrap);
    end
  endtask

  task automatic test_triangle();
    int want;
    dif.func = 3'd2;
    cycle();
    for (int n = 1; n <= 256; n++) begin
      cycle();
      nvec++;
      if (dif.wave !== W'(m_wave) || dif.wrap !== m_wrap[0]) begin
        nerr++;
        $display("FAIL tri_model n=%0d got=%0d/%0b want=%0d/%0d",
                 n, dif.wave, dif.wrap, m_wave, m_wrap);
      end
      want = -1;
      case (n)
        65:  want = 128;
        129: want = 255;
        193: want = 127;
        256: want = 1;
        default: want = -1;
      endcase
      if (want >= 0) begin
        nvec++;
        if (dif.wave !== W'(want)) begin
          nerr++;
          $display("FAIL tri_point p=%0d got=%0d want=%0d",
                   n - 1, dif.wave, want);
        end
      end
    end
  endtask

  task automatic test_square();
    int p, want;
    dif.func = 3'd3; dif.duty = 8'd64; dif.atten = 3'd0;
    cycle();
    for (int n = 1; n <= 768; n++) begin
      if (n == 257) dif.atten = 3'd2;
      if (n == 513) dif.duty = 8'd0;
      cycle();
      p = (n - 1) % 256;
      if (n > 512)      want = 0;
      else if (n > 256) want = (p < 64) ? 63 : 0;
      else              want = (p < 64) ? 255 : 0;
      nvec++;
      if (dif.wave !== W'(want)) begin
        nerr++;
        $display("FAIL square n=%0d p=%0d got=%0d want=%0d",
                 n, p, dif.wave, want);
      end
    end
    dif.atten = 3'd0;
  endtask

  task automatic test_mode_switch();
    int want;
    dif.func = 3'd0;
    cycle();
    repeat (80) cycle();
    dif.func = 3'd6;
    cycle();
    nvec++;
    if (dif.wrap !== 1'b0 || dif.wave !== W'(m_wave)) begin
      nerr++;
      $display("FAIL switch_edge got=%0d/%0b want=%0d/0",
               dif.wave, dif.wrap, m_wave);
    end
    for (int n = 1; n <= 129; n++) begin
      cycle();
      want = -1;
      if (n == 1 || n == 129) want = 0;
      if (n == 65) want = 254;
      if (want >= 0) begin
        nvec++;
        if (dif.wave !== W'(want)) begin
          nerr++;
          $display("FAIL sine n=%0d got=%0d want=%0d",
                   n, dif.wave, want);
        end
      end
    end
  endtask

  task automatic test_noise();
    int seq[4] = '{'h01, 'hB8, 'h5C, 'h2E};
    async_reset();
    dif.func = 3'd5; dif.step = 16'h0100; dif.atten = 3'd0;
    for (int n = 1; n <= 256; n++) begin
      cycle();
      nvec++;
      if (dif.wave === '0 || dif.wave !== W'(m_wave)) begin
        nerr++;
        $display("FAIL noise n=%0d got=%0h want=%0h",
                 n, dif.wave, m_wave);
      end
      if (n <= 4) begin
        nvec++;
        if (dif.wave !== W'(seq[n-1])) begin
          nerr++;
          $display("FAIL noise_seq n=%0d got=%0h want=%0h",
                   n, dif.wave, seq[n-1]);
        end
      end
    end
    nvec++;
    if (dif.wave !== 8'h01) begin
      nerr++;
      $display("FAIL noise_period got=%0h want=01", dif.wave);
    end
    dif.en = 1'b0;
    repeat (10) begin
      cycle();
      nvec++;
      if (dif.wave !== 8'h01 || dif.wrap !== 1'b0) begin
        nerr++;
        $display("FAIL noise_hold got=%0h/%0b want=01/0",
                 dif.wave, dif.wrap);
      end
    end
    dif.en = 1'b1;
    cycle();
    nvec++;
    if (dif.wave !== 8'hB8) begin
      nerr++;
      $display("FAIL noise_resume got=%0h want=b8", dif.wave);
    end
  endtask

  task automatic test_hold();
    int nwrap;
    int att[3] = '{50, 25, 12};
    async_reset();
    dif.func = 3'd0; dif.step = 16'h0100; dif.atten = 3'd0;
    repeat (101) cycle();
    dif.func = 3'd7;
    nwrap = 0;
    for (int n = 0; n <= 600; n++) begin
      cycle();
      if (dif.wrap === 1'b1) nwrap++;
      nvec++;
      if (dif.wave !== 8'd100 || dif.wrap !== m_wrap[0]) begin
        nerr++;
        $display("FAIL hold n=%0d got=%0d/%0b want=100/%0d",
                 n, dif.wave, dif.wrap, m_wrap);
      end
    end
    nvec++;
    if (nwrap != 2) begin
      nerr++;
      $display("FAIL hold_wrap_count got=%0d want=2", nwrap);
    end
    dif.step = 16'h0000;
    nwrap = 0;
    repeat (1000) begin
      cycle();
      if (dif.wrap !== 1'b0) nwrap++;
    end
    nvec++;
    if (nwrap != 0) begin
      nerr++;
      $display("FAIL step0_wrap got=%0d want=0", nwrap);
    end
    dif.atten = 3'd1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      nvec++;
      if (dif.wave !== W'(att[i])) begin
        nerr++;
        $display("FAIL hold_atten i=%0d got=%0d want=%0d",
                 i, dif.wave, att[i]);
      end
    end
    dif.atten = 3'd0;
    dif.step = 16'hFFFF;
    dif.func = 3'd0;
    for (int n = 0; n < 20; n++) begin
      cycle();
      nvec++;
      if (dif.wrap !== (n >= 2)) begin
        nerr++;
        $display("FAIL stepmax_wrap n=%0d got=%0b want=%0b",
                 n, dif.wrap, n >= 2);
      end
    end
  endtask

  task automatic test_random();
    async_reset();
    dif.duty = 8'($urandom);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0)
        dif.func = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0)
        dif.duty = 8'($urandom);
      if ($urandom_range(0, 31) == 0)
        dif.atten = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 3))
          0: dif.step = 16'($urandom);
          1: dif.step = 16'($urandom_range(0, 255));
          2: dif.step = 16'h0000;
          default: dif.step = 16'hFFFF;
        endcase
      end
      dif.en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 499) == 0) async_reset();
      cycle();
      nvec++;
      if (dif.wave !== W'(m_wave) || dif.wrap !== m_wrap[0]) begin
        nerr++;
        $display("FAIL random n=%0d func=%0d got=%0d/%0b want=%0d/%0d",
                 n, dif.func, dif.wave, dif.wrap, m_wave, m_wrap);
      end
    end
  endtask

  initial begin
    dif.en = 1'b0; dif.func = 3'd0; dif.step = '0;
    dif.duty = '0; dif.atten = 3'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_triangle();
    test_square();
    test_mode_switch();
    test_noise();
    test_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
